// File: rtl/counter_pkg.sv
// Shared encodings for the 4-bit counter family sequencer: counter modes,
// per-mode seed values, controller FSM states and the decade wrap point.
package counter_pkg;

  localparam logic [1:0] MODE_RING    = 2'd0;
  localparam logic [1:0] MODE_JOHNSON = 2'd1;
  localparam logic [1:0] MODE_DECADE  = 2'd2;
  localparam logic [1:0] MODE_BIN     = 2'd3;

  localparam int SEED_RING    = 1;
  localparam int SEED_JOHNSON = 0;
  localparam int SEED_DECADE  = 0;
  localparam int SEED_BIN     = 0;

  localparam int DECADE_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int seed_value(input logic [1:0] mode);
    case (mode)
      MODE_RING:    return SEED_RING;
      MODE_JOHNSON: return SEED_JOHNSON;
      MODE_DECADE:  return SEED_DECADE;
      default:      return SEED_BIN;
    endcase
  endfunction

endpackage

// File: rtl/counter_step_fn.sv
// Combinational next-value function shared by every counter mode; the
// controller feeds it the one shared count register.
module counter_step_fn
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q + WIDTH'(1);
    case (mode)
      MODE_RING:    next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_JOHNSON: next_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
      MODE_DECADE:  next_q = (q == WIDTH'(DECADE_MAX)) ? '0 : q + WIDTH'(1);
      default:      next_q = q + WIDTH'(1);
    endcase
  end

endmodule

// File: rtl/counter_run_controller.sv
// Run sequencer: accepts a start, seeds the chosen counter pattern, steps it
// run_len times (honouring pause/abort) and pulses done when finished.
module counter_run_controller
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] run_len,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic [LEN_W-1:0] step_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic [1:0]       mode_r;
  logic [LEN_W-1:0] len_r;
  logic [WIDTH-1:0] next_q;
  logic [LEN_W-1:0] cnt_inc;

  assign cnt_inc = step_cnt + LEN_W'(1);

  counter_step_fn #(.WIDTH(WIDTH)) u_step (
    .q      (q),
    .mode   (mode_r),
    .next_q (next_q)
  );

  // done and err are single-cycle pulses, so they default low every edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      q        <= '0;
      step_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mode_r   <= MODE_RING;
      len_r    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (run_len != '0) begin
              q        <= WIDTH'(seed_value(mode));
              step_cnt <= '0;
              mode_r   <= mode;
              len_r    <= run_len;
              busy     <= 1'b1;
              state    <= ST_RUN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (!pause) begin
            q        <= next_q;
            step_cnt <= cnt_inc;
            if (cnt_inc == len_r) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
